// File: rtl/out_channel_checker.sv
// out_channel_checker: receives a program's out-channel words over a
// valid/ready stream and checks them, in order, against an expected table.
// Reports finished/success plus timeout, overrun and first-mismatch index.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2,
  parameter int MaxSteps           = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          loadValid,
  input  logic [7:0]                    loadIndex,
  input  logic [MemoryElementWidth-1:0] loadValue,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  output logic                          finished,
  output logic                          success,
  output logic                          timedOut,
  output logic                          overrun,
  output logic [7:0]                    mismatchIndex,
  output logic [7:0]                    received
);

  // A zero-entry table still needs one physical slot to be legal.
  localparam int Depth = (NOut > 0) ? NOut : 1;
  localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  // The step counter must be able to hold MaxSteps itself.
  localparam int StepW = $clog2(MaxSteps + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state;
  logic [MemoryElementWidth-1:0] exp_mem [Depth];
  logic [StepW-1:0]              steps;
  logic                          mismatch;

  logic                          transfer;
  logic                          load_ok;
  logic [StepW-1:0]              steps_next;
  logic                          step_limit;
  logic                          last_word;
  logic                          word_bad;
  logic [IdxW-1:0]               rd_idx;

  assign outReady   = (state != S_IDLE);
  assign finished   = (state == S_DONE);
  assign transfer   = outValid && outReady;
  assign load_ok    = loadValid && (state != S_RUN) && (int'(loadIndex) < NOut);
  assign steps_next = steps + 1'b1;
  assign step_limit = (steps_next == StepW'(MaxSteps));
  assign last_word  = (NOut > 0) && (received == 8'(NOut - 1));
  assign rd_idx     = received[IdxW-1:0];
  assign word_bad   = (outData != exp_mem[rd_idx]);

  // Expected-value table: written only outside RUN, contents kept over reset.
  // NOTE: the table has no reset branch on purpose -- it must survive reset,
  // and leaving it out lets synthesis map it onto plain RAM/LUT storage.
  always_ff @(posedge clock) begin
    if (load_ok) exp_mem[loadIndex[IdxW-1:0]] <= loadValue;
  end

  // Control FSM: start, per-word compare, completion, timeout and overrun.
  // NOTE: every register here uses non-blocking assignment so that all
  // reads in this block see the pre-edge values, exactly like the hardware.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      steps         <= '0;
      mismatch      <= 1'b0;
      success       <= 1'b0;
      timedOut      <= 1'b0;
      overrun       <= 1'b0;
      mismatchIndex <= 8'd0;
      received      <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (run) begin
            state         <= S_RUN;
            steps         <= '0;
            mismatch      <= 1'b0;
            success       <= 1'b0;
            timedOut      <= 1'b0;
            overrun       <= 1'b0;
            mismatchIndex <= 8'd0;
            received      <= 8'd0;
          end else if (state == S_DONE && transfer) begin
            // A word after the check completed: flag it, never compare it.
            overrun <= 1'b1;
            success <= 1'b0;
            if (received != 8'd255) received <= received + 8'd1;
          end
        end

        S_RUN: begin
          steps <= steps_next;
          if (NOut == 0) begin
            // Nothing expected: finish after one cycle; any word is surplus.
            state   <= S_DONE;
            success <= !transfer;
            if (transfer) begin
              overrun  <= 1'b1;
              received <= 8'd1;
            end
          end else if (transfer) begin
            received <= received + 8'd1;
            if (word_bad && !mismatch) begin
              mismatch      <= 1'b1;
              mismatchIndex <= received;
            end
            if (last_word) begin
              // Completion beats a timeout landing on the same edge.
              state   <= S_DONE;
              success <= !(mismatch || word_bad);
            end else if (step_limit) begin
              state    <= S_DONE;
              timedOut <= 1'b1;
              success  <= 1'b0;
            end
          end else if (step_limit) begin
            state    <= S_DONE;
            timedOut <= 1'b1;
            success  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Testbench for out_channel_checker: directed scenarios on a NOut=2,
// MaxSteps=10 instance, a NOut=0 instance, and randomized checks on a
// NOut=8, MaxSteps=40 instance against a schedule-level outcome model.
module tb_out_channel_checker;

  localparam int W       = 12;
  localparam int RNOut   = 8;
  localparam int RSteps  = 40;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         run = 1'b0;
  logic         loadValid = 1'b0;
  logic [7:0]   loadIndex = 8'd0;
  logic [W-1:0] loadValue = '0;
  logic         outValid = 1'b0;
  logic [W-1:0] outData = '0;

  logic m_rdy, m_fin, m_suc, m_to, m_ov;
  logic [7:0] m_mi, m_rc;
  logic z_rdy, z_fin, z_suc, z_to, z_ov;
  logic [7:0] z_mi, z_rc;
  logic r_rdy, r_fin, r_suc, r_to, r_ov;
  logic [7:0] r_mi, r_rc;

  int tests = 0;
  int fails = 0;
  logic [20:0] want;

  always #5 clock = ~clock;

  out_channel_checker #(.MemoryElementWidth(W), .NOut(2), .MaxSteps(10)) u_main (
    .clock(clock), .reset(reset), .run(run), .loadValid(loadValid),
    .loadIndex(loadIndex), .loadValue(loadValue), .outValid(outValid),
    .outData(outData), .outReady(m_rdy), .finished(m_fin), .success(m_suc),
    .timedOut(m_to), .overrun(m_ov), .mismatchIndex(m_mi), .received(m_rc));

  out_channel_checker #(.MemoryElementWidth(W), .NOut(0), .MaxSteps(10)) u_zero (
    .clock(clock), .reset(reset), .run(run), .loadValid(loadValid),
    .loadIndex(loadIndex), .loadValue(loadValue), .outValid(outValid),
    .outData(outData), .outReady(z_rdy), .finished(z_fin), .success(z_suc),
    .timedOut(z_to), .overrun(z_ov), .mismatchIndex(z_mi), .received(z_rc));

  out_channel_checker #(.MemoryElementWidth(W), .NOut(RNOut), .MaxSteps(RSteps)) u_rand (
    .clock(clock), .reset(reset), .run(run), .loadValid(loadValid),
    .loadIndex(loadIndex), .loadValue(loadValue), .outValid(outValid),
    .outData(outData), .outReady(r_rdy), .finished(r_fin), .success(r_suc),
    .timedOut(r_to), .overrun(r_ov), .mismatchIndex(r_mi), .received(r_rc));

  // Packed status: {outReady, finished, success, timedOut, overrun, mismatchIndex, received}
  function automatic logic [20:0] mk(input logic rdy, input logic fin, input logic suc,
                                     input logic to, input logic ov,
                                     input logic [7:0] mi, input logic [7:0] rc);
    return {rdy, fin, suc, to, ov, mi, rc};
  endfunction

  function automatic logic [20:0] st_m();
    return {m_rdy, m_fin, m_suc, m_to, m_ov, m_mi, m_rc};
  endfunction

  function automatic logic [20:0] st_z();
    return {z_rdy, z_fin, z_suc, z_to, z_ov, z_mi, z_rc};
  endfunction

  function automatic logic [20:0] st_r();
    return {r_rdy, r_fin, r_suc, r_to, r_ov, r_mi, r_rc};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [7:0] idx, input logic [W-1:0] val);
    loadValid = 1'b1; loadIndex = idx; loadValue = val;
    tick();
    loadValid = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w);
    outValid = 1'b1; outData = w;
    tick();
    outValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    want = mk(0, 0, 0, 0, 0, 8'd0, 8'd0);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL reset_main got=%h want=%h", st_m(), want); end
    tests++;
    if (st_z() !== want) begin fails++; $display("FAIL reset_zero got=%h want=%h", st_z(), want); end
    reset = 1'b0;
  endtask

  task automatic test_match();
    load(8'd0, 12'd2);
    load(8'd1, 12'd1);
    start();
    want = mk(1, 0, 0, 0, 0, 8'd0, 8'd0);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL match_start got=%h want=%h", st_m(), want); end
    send(12'd2);
    want = mk(1, 0, 0, 0, 0, 8'd0, 8'd1);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL match_first got=%h want=%h", st_m(), want); end
    send(12'd1);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL match_done got=%h want=%h", st_m(), want); end
    idle(2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL match_hold got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_mismatch();
    start();
    send(12'd2);
    send(12'd7);
    want = mk(1, 1, 0, 0, 0, 8'd1, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL mismatch_done got=%h want=%h", st_m(), want); end
    start();
    send(12'd2);
    idle(3);
    send(12'd1);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL gaps_rerun got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_overrun();
    start();
    send(12'd2);
    send(12'd1);
    send(12'd5);
    want = mk(1, 1, 0, 0, 1, 8'd0, 8'd3);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL overrun got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_timeout();
    start();
    send(12'd2);
    idle(8);
    want = mk(1, 0, 0, 0, 0, 8'd0, 8'd1);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL timeout_edge9 got=%h want=%h", st_m(), want); end
    idle(1);
    want = mk(1, 1, 0, 1, 0, 8'd0, 8'd1);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL timeout_edge10 got=%h want=%h", st_m(), want); end
    start();
    send(12'd2);
    idle(8);
    send(12'd1);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL last_on_limit got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_reset_mid_run();
    start();
    send(12'd2);
    reset = 1'b1;
    tick();
    want = mk(0, 0, 0, 0, 0, 8'd0, 8'd0);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL reset_mid got=%h want=%h", st_m(), want); end
    reset = 1'b0;
    load(8'd0, 12'd2);
    load(8'd1, 12'd1);
    start();
    send(12'd2);
    send(12'd1);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL reset_rerun got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_load_rules();
    // A load during RUN must be ignored.
    start();
    load(8'd0, 12'd9);
    send(12'd2);
    send(12'd1);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL load_in_run got=%h want=%h", st_m(), want); end
    // Load and run on the same IDLE edge: the new entry is used.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    loadValid = 1'b1; loadIndex = 8'd1; loadValue = 12'd5; run = 1'b1;
    tick();
    loadValid = 1'b0; run = 1'b0;
    send(12'd2);
    send(12'd5);
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL load_with_run got=%h want=%h", st_m(), want); end
    // Out-of-range index ignored: entry 1 still holds 5.
    load(8'd2, 12'd7);
    start();
    send(12'd2);
    send(12'd5);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL load_oob got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_run_in_run();
    start();
    send(12'd2);
    run = 1'b1; outValid = 1'b1; outData = 12'd5;
    tick();
    run = 1'b0; outValid = 1'b0;
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd2);
    tests++;
    if (st_m() !== want) begin fails++; $display("FAIL run_in_run got=%h want=%h", st_m(), want); end
  endtask

  task automatic test_nout_zero();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start();
    want = mk(1, 0, 0, 0, 0, 8'd0, 8'd0);
    tests++;
    if (st_z() !== want) begin fails++; $display("FAIL zero_run got=%h want=%h", st_z(), want); end
    tick();
    want = mk(1, 1, 1, 0, 0, 8'd0, 8'd0);
    tests++;
    if (st_z() !== want) begin fails++; $display("FAIL zero_done got=%h want=%h", st_z(), want); end
  endtask

  task automatic test_random();
    logic [W-1:0] ex [RNOut];
    logic [W-1:0] wd [RNOut];
    int at [RNOut];
    int c, acc, end_e, mi;
    logic bad, done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < RNOut; i++) begin
        ex[i] = W'($urandom);
        load(8'(i), ex[i]);
      end
      load(8'($urandom_range(RNOut, 255)), W'($urandom));
      c = 0;
      for (int i = 0; i < RNOut; i++) begin
        wd[i] = ($urandom_range(0, 3) == 0) ? (ex[i] ^ W'($urandom_range(1, 4095))) : ex[i];
        c += $urandom_range(1, 6);
        at[i] = c;
      end
      // Outcome model: words landing at or before the step limit are accepted.
      acc = 0; mi = 0; bad = 1'b0; done = 1'b0; end_e = RSteps;
      for (int i = 0; i < RNOut; i++) begin
        if (at[i] <= RSteps) begin
          acc++;
          if (!bad && wd[i] != ex[i]) begin bad = 1'b1; mi = i; end
          if (i == RNOut - 1) begin done = 1'b1; end_e = at[i]; end
        end
      end
      start();
      for (int e = 1; e <= end_e; e++) begin
        outValid = 1'b0;
        for (int i = 0; i < RNOut; i++)
          if (at[i] == e) begin outValid = 1'b1; outData = wd[i]; end
        tick();
        outValid = 1'b0;
        if (e < end_e) begin
          tests++;
          if ({r_rdy, r_fin} !== 2'b10) begin
            fails++;
            $display("FAIL rand_busy t=%0d e=%0d got=%b want=10", t, e, {r_rdy, r_fin});
          end
        end
      end
      want = mk(1, 1, done && !bad, !done, 0, 8'(mi), 8'(acc));
      tests++;
      if (st_r() !== want) begin fails++; $display("FAIL rand_end t=%0d got=%h want=%h", t, st_r(), want); end
      if ($urandom_range(0, 1) == 1) begin
        send(W'($urandom));
        want = mk(1, 1, 0, !done, 1, 8'(mi), 8'(acc + 1));
        tests++;
        if (st_r() !== want) begin fails++; $display("FAIL rand_overrun t=%0d got=%h want=%h", t, st_r(), want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_overrun();
    test_timeout();
    test_reset_mid_run();
    test_load_rules();
    test_run_in_run();
    test_nout_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
